// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : bytes packed into one instruction word
//   insert_lane()  : drops a byte into one lane of a 32-bit word
package instr_loader_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam int unsigned HDR_BYTES      = 4;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 2;

    // Header and data words are both 4 bytes, so a single packer serves both.
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 32'd1);

    function automatic logic [31:0] insert_lane(
        input logic [31:0]       word,
        input logic [LANE_W-1:0] lane,
        input logic [7:0]        data
    );
        logic [31:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream / memory-write bundle of the instruction loader.
//   rx_valid_i, rx_data_i           : UART byte strobe and byte
//   mem_we_o, mem_addr_o, mem_wdata_o : instruction-memory write port
// master : environment side (drives bytes, observes writes)
// slave  : loader side (consumes bytes, drives writes)
interface instr_loader_if;

    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;

    modport master (
        output rx_valid_i, rx_data_i,
        input  mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  rx_valid_i, rx_data_i,
        output mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/instr_word_packer.sv
// Little-endian byte-to-word packer shared by the header and data paths.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : drop any partial word and restart at lane 0
//   valid_i       : accept byte_i into the current lane
//   byte_i        : incoming byte
//   word_o        : word including byte_i (meaningful when word_valid_o)
//   word_valid_o  : byte_i completed a word this cycle
//   lane_nxt_o    : lane the next accepted byte will occupy
module instr_word_packer
    import instr_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [7:0]        byte_i,
    output logic [31:0]       word_o,
    output logic              word_valid_o,
    output logic [LANE_W-1:0] lane_nxt_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       word_q, word_d;

    // Next lane / partial word, and completion of a word
    always_comb begin
        lane_d       = lane_q;
        word_d       = word_q;
        word_valid_o = 1'b0;
        word_o       = insert_lane(word_q, lane_q, byte_i);
        if (clr_i) begin
            lane_d = '0;
            word_d = 32'h0000_0000;
        end else if (valid_i) begin
            word_d       = word_o;
            // Lane counter wraps naturally back to 0 after the top lane.
            lane_d       = lane_q + LANE_W'(1);
            word_valid_o = (lane_q == LANE_LAST);
        end else begin
            lane_d = lane_q;
        end
        lane_nxt_o = lane_d;
    end

    // Lane counter and partial-word register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            word_q <= 32'h0000_0000;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time loader: reads a 4-byte little-endian word count, then packs the
// following bytes into words written to instruction memory from address 0,
// holding the core in reset until the load completes.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : UART byte stream in, instruction-memory write port out
//   core_rst_o    : active-high core reset, released once loading is done
//   busy_o        : partial header received, or data phase in progress
//   done_o        : load complete (sticky until reset)
//   err_o         : header exceeded DEPTH_WORDS (sticky until reset)
// DEPTH_WORDS must be at least 2.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    instr_loader_if.slave bus,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned      CNT_W     = $clog2(DEPTH_WORDS) + 1;
    localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [31:0]      DEPTH_W32 = 32'(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept_s;
    logic               tmo_run_s;
    logic               timeout_s;
    logic [31:0]        pk_word_s;
    logic               pk_valid_s;
    logic [LANE_W-1:0]  pk_lane_nxt_s;

    instr_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (timeout_s),
        .valid_i      (accept_s),
        .byte_i       (bus.rx_data_i),
        .word_o       (pk_word_s),
        .word_valid_o (pk_valid_s),
        .lane_nxt_o   (pk_lane_nxt_s)
    );

    // Byte acceptance and idle-timeout detection
    always_comb begin
        accept_s  = bus.rx_valid_i && ((state_q == HDR) || (state_q == DATA));
        // busy_q is registered from "next state is DATA, or HDR with a partial
        // header", which is exactly when the idle timer has to run.
        tmo_run_s = busy_q;
        timeout_s = tmo_run_s && !bus.rx_valid_i && (tmo_q == TMO_LAST);
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (timeout_s) begin
                    state_d = HDR;
                end else if (pk_valid_s) begin
                    if (pk_word_s == 32'h0000_0000) begin
                        state_d = DONE;
                    end else if (pk_word_s > DEPTH_W32) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = HDR;
                end
            end
            DATA: begin
                // Completion is judged in the strobe cycle, after the count
                // has already moved past the final word.
                if (timeout_s) begin
                    state_d = HDR;
                end else if (mem_we_q && (32'(word_cnt_q) == len_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = HDR;
        endcase
    end

    // FSM outputs, decoded from the next state so they register with it
    always_comb begin
        core_rst_d = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_d)
            HDR:     busy_d     = (pk_lane_nxt_s != '0);
            DATA:    busy_d     = 1'b1;
            DONE: begin
                core_rst_d = 1'b0;
                done_d     = 1'b1;
            end
            ERR:     err_d      = 1'b1;
            default: core_rst_d = 1'b1;
        endcase
    end

    // Length, word counter, idle timer and memory write port
    always_comb begin
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (timeout_s) begin
            // Resync only; words already written stay in memory.
            len_d      = 32'h0000_0000;
            word_cnt_d = '0;
            tmo_d      = '0;
        end else begin
            if (accept_s) begin
                tmo_d = '0;
            end else if (tmo_run_s) begin
                tmo_d = tmo_q + TMO_W'(1);
            end else begin
                tmo_d = '0;
            end
            if (pk_valid_s && (state_q == HDR)) begin
                len_d      = pk_word_s;
                word_cnt_d = '0;
            end else if (pk_valid_s && (state_q == DATA)) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = pk_word_s;
                // Top count bit only flags "all words written"; it never
                // reaches the address.
                mem_addr_d  = 32'({word_cnt_q[CNT_W-2:0], 2'b00});
                word_cnt_d  = word_cnt_q + CNT_W'(1);
            end else begin
                word_cnt_d = word_cnt_q;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q       <= 32'h0000_0000;
            word_cnt_q  <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign core_rst_o      = core_rst_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: byte streams with random data and
// gaps, compared against a stream-level reference model.
module tb_instr_loader;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned TMO   = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic core_rst, busy, done, err;

    instr_loader_if bus ();

    instr_loader #(.DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .core_rst_o (core_rst),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] got_addr[$], got_data[$];
    logic [31:0] exp_addr[$], exp_data[$];

    // Record every write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1) begin
            got_addr.push_back(bus.mem_addr_o);
            got_data.push_back(bus.mem_wdata_o);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(posedge clk);
        #1 bus.rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stream-level model: header count, then little-endian words at 4*index
    task automatic model(input logic [7:0] s[$], output bit exp_err);
        logic [31:0] len;
        exp_addr.delete();
        exp_data.delete();
        len = {s[3], s[2], s[1], s[0]};
        exp_err = (len > DEPTH);
        if (!exp_err) begin
            for (int w = 0; w < int'(len); w++) begin
                exp_addr.push_back(32'(w) * 32'd4);
                exp_data.push_back({s[4*w+7], s[4*w+6], s[4*w+5], s[4*w+4]});
            end
        end
    endtask

    task automatic run_stream(input logic [7:0] s[$], input int max_gap, input string tag);
        bit exp_err;
        model(s, exp_err);
        foreach (s[i]) begin
            if (i != 0) idle(int'($urandom_range(max_gap, 0)));
            send(s[i]);
        end
        idle(4);
        @(negedge clk);
        n_cmp++;
        if (got_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s strobe_count: got %0d expected %0d", tag, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            n_cmp++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got %h/%h expected %h/%h", tag, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if ({done, err, core_rst, busy} !== (exp_err ? 4'b0110 : 4'b1000)) begin
            n_fail++;
            $display("FAIL %s final_status done/err/core_rst/busy: got %b expected %b", tag, {done, err, core_rst, busy}, (exp_err ? 4'b0110 : 4'b1000));
        end
    endtask

    task automatic test_reset();
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== 65'd0) begin
            n_fail++;
            $display("FAIL reset_mem: got %b/%h/%h expected 0/0/0", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        n_cmp++;
        if ({core_rst, busy, done, err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_status core_rst/busy/done/err: got %b expected 1000", {core_rst, busy, done, err});
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({core_rst, busy, done, err, bus.mem_we_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 10000", {core_rst, busy, done, err, bus.mem_we_o});
        end
    endtask

    task automatic test_example();
        logic [7:0] s[$];
        bit exp_err;
        do_reset();
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        model(s, exp_err);
        foreach (s[i]) send(s[i]);
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, done, core_rst} !== {1'b1, 32'h4, 32'h0010_0093, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL example_last_strobe we/addr/data/done/core_rst: got %b/%h/%h/%b/%b expected 1/00000004/00100093/0/1", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, done, core_rst);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, core_rst, busy, bus.mem_we_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL example_done_timing done/core_rst/busy/we: got %b expected 1000", {done, core_rst, busy, bus.mem_we_o});
        end
        n_cmp++;
        if (got_addr.size() != 2 || got_addr[0] !== 32'h0 || got_data[0] !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL example_first_write: got count %0d expected 2 with 00000000/00000013", got_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            n_cmp++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL example_write[%0d]: got %h/%h expected %h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h00);
        @(negedge clk);
        n_cmp++;
        if ({done, core_rst, busy, err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL len_zero_done done/core_rst/busy/err: got %b expected 1000", {done, core_rst, busy, err});
        end
        for (int i = 0; i < 8; i++) send(8'($urandom));
        idle(3);
        @(negedge clk);
        n_cmp++;
        if (got_addr.size() != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL len_zero_ignore: got %0d writes done=%b expected 0 writes done=1", got_addr.size(), done);
        end
    endtask

    task automatic test_len_err();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h01, 8'h04, 8'h00, 8'h00};
        foreach (s[i]) send(s[i]);
        @(negedge clk);
        n_cmp++;
        if ({err, core_rst, done, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL len_err_status err/core_rst/done/busy: got %b expected 1100", {err, core_rst, done, busy});
        end
        for (int i = 0; i < 12; i++) send(8'($urandom));
        idle(3);
        @(negedge clk);
        n_cmp++;
        if (got_addr.size() != 0 || {err, core_rst, done} !== 3'b110) begin
            n_fail++;
            $display("FAIL len_err_ignore: got %0d writes err/core_rst/done=%b expected 0 writes 110", got_addr.size(), {err, core_rst, done});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h03, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
        run_stream(s, 0, "back_to_back");
        n_cmp++;
        if (got_addr.size() != 3 || got_addr[0] !== 32'h0 || got_addr[1] !== 32'h4 || got_addr[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL back_to_back_addrs: got count %0d expected 3 at 0/4/8", got_addr.size());
        end
    endtask

    task automatic test_random_loads();
        logic [7:0] s[$];
        int unsigned len;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            len = $urandom_range(8, 1);
            s = '{8'(len), 8'h00, 8'h00, 8'h00};
            for (int i = 0; i < int'(len) * 4; i++) s.push_back(8'($urandom));
            // trailing bytes after the load must be ignored
            for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
            run_stream(s, 3, $sformatf("random_%0d", it));
        end
    endtask

    task automatic test_max_depth();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h00, 8'h04, 8'h00, 8'h00};
        for (int i = 0; i < int'(DEPTH) * 4; i++) s.push_back(8'($urandom));
        run_stream(s, 0, "max_depth");
        n_cmp++;
        if (((got_addr.size() == DEPTH) ? got_addr[DEPTH-1] : 32'hFFFF_FFFF) !== 32'h0000_0FFC) begin
            n_fail++;
            $display("FAIL max_depth_last_addr: got count %0d expected last addr 00000ffc", got_addr.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        do_reset();
        send(8'h03);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first_hdr_byte: got %b expected 1", busy);
        end
        send(8'h00); send(8'h00); send(8'h00);
        send(8'h5A);
        idle(TMO / 2);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_timeout: got %b expected 1", busy);
        end
        idle(TMO + 4);
        @(negedge clk);
        n_cmp++;
        if ({busy, core_rst, done, err} !== 4'b0100 || got_addr.size() != 0) begin
            n_fail++;
            $display("FAIL data_timeout busy/core_rst/done/err: got %b writes %0d expected 0100 writes 0", {busy, core_rst, done, err}, got_addr.size());
        end
        send(8'h07); send(8'h00);
        idle(TMO + 4);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL header_timeout busy: got %b expected 0", busy);
        end
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_stream(s, 2, "after_timeout");
        n_cmp++;
        if (got_addr.size() != 1 || got_addr[0] !== 32'h0 || got_data[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL after_timeout_write: got count %0d expected 1 write deadbeef at 0", got_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (s[i]) send(s[i]);
        n_cmp++;
        if (bus.mem_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_strobe: got %b expected 1", bus.mem_we_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, core_rst, busy, done, err} !== {1'b0, 32'h0, 32'h0, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_during_strobe: got %b/%h/%h/%b expected 0/0/0/1000", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, {core_rst, busy, done, err});
        end
        idle(2);
        rst_n = 1'b1;
        idle(10);
        @(negedge clk);
        n_cmp++;
        if (got_addr.size() != 0 || {core_rst, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL stray_write_after_reset: got %0d writes status %b expected 0 writes 100", got_addr.size(), {core_rst, busy, done});
        end
        // partial word then reset: the next load must start from lane 0
        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        foreach (s[i]) send(s[i]);
        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(s, 0, "after_mid_reset");
        n_cmp++;
        if (got_addr.size() != 1 || got_data[0] !== 32'h4433_2211) begin
            n_fail++;
            $display("FAIL after_mid_reset_word: got count %0d expected 1 write 44332211", got_addr.size());
        end
    endtask

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        test_reset();
        test_example();
        test_len_zero();
        test_len_err();
        test_back_to_back();
        test_random_loads();
        test_max_depth();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time controller that fills instruction memory from a UART byte stream and holds the core in reset until loading completes. Receives a 4-byte little-endian word-count header, then packs the following bytes little-endian into 32-bit words and issues one write strobe per word at word-aligned addresses starting at 0. Sits between the UART receiver and the instruction memory's write port and drives the core's reset. It is the only writer of instruction memory.

## Interface
- DEPTH_WORDS, 1024: instruction memory capacity in words; also the largest legal header value.
- TIMEOUT_CYCLES, 1_000_000: idle cycles allowed between bytes of a header or data block before resync.
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i holds a received byte.
- rx_data_i  in  8  received byte.
- mem_we_o  out  1  instruction memory write strobe, one cycle per word.
- mem_addr_o  out  32  byte address of the word being written, always 4-aligned.
- mem_wdata_o  out  32  packed word.
- core_rst_o  out  1  active-high core reset; high until load completes.
- busy_o  out  1  header or data reception in progress.
- done_o  out  1  load complete; stays high until reset.
- err_o  out  1  header exceeded DEPTH_WORDS; stays high until reset.

## Operation
- States: HDR, DATA, DONE, ERR. The reset state is HDR.
- Reset values: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1, busy_o=0, done_o=0, err_o=0. Byte counter, word counter and timeout counter are 0.
- **HDR state**
  - Each rx_valid_i byte shifts into the length register, LSB byte first.
  - After the 4th byte:
    - len=0 goes to DONE.
    - len>DEPTH_WORDS goes to ERR.
    - Otherwise goes to DATA, with word counter at 0.
- **DATA state**
  - Bytes fill lanes [7:0], [15:8], [23:16], [31:24] in order.
  - On the 4th byte the assembled word is registered to mem_wdata_o and mem_addr_o = word_cnt*4. mem_we_o pulses on the next cycle, then word_cnt increments.
  - When word_cnt reaches len after the final write, go to DONE.
- **DONE state**: core_rst_o=0 and done_o=1. All further rx bytes are ignored.
- **ERR state**: err_o=1 and core_rst_o=1. Bytes are ignored; only rst_ni exits.
- busy_o=1 in HDR once at least one header byte has been received, and throughout DATA.
- **Timeout**
  - The counter runs in HDR with a partial header, and in DATA. It clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES: return to HDR and clear the byte counter, word counter and length.
  - Memory already written is not erased. err_o is not set.
- Address width rule: word_cnt is clog2(DEPTH_WORDS)+1 bits. mem_addr_o is zero-extended, so it never exceeds (DEPTH_WORDS-1)*4.

## Timing
- Byte sampled on the rising clk_i edge where rx_valid_i=1; no backpressure.
- Byte accepted at edge N completing a word: mem_addr_o/mem_wdata_o valid from N+1, with mem_we_o=1 only in cycle N+1.
- A byte arriving in the same cycle as the mem_we_o pulse is accepted as lane 0 of the next word, with no loss. Back-to-back bytes every cycle must be supported.
- Final word: mem_we_o in cycle N+1; done_o rises and core_rst_o falls at N+2.
- Header with len=0: done_o at the cycle after the 4th header byte.
- rst_ni low at any point, including mid-word or during mem_we_o: all outputs return to reset values immediately. A pending write is dropped and never emitted after reset release.
- mem_addr_o/mem_wdata_o hold their last values between strobes.

## Structure
- Package instr_loader_pkg holds:
  - state enum (HDR, DATA, DONE, ERR)
  - HDR_BYTES=4
  - BYTES_PER_WORD=4
- Natural sub-module: instr_word_packer.
  - Handles the lane counter and shift/pack.
  - Outputs word and word_valid.
  - Clear input driven by timeout.
  - Shared by the header and data paths.
- FSM, word counter and timeout counter live in instr_loader.

## Test plan
- Header 02 00 00 00, data 13 00 00 00 93 00 10 00:
  - mem_we_o twice: addr 0x0/data 0x00000013, then addr 0x4/data 0x00100093.
  - done_o=1 and core_rst_o=0 two cycles after the last byte.
- Header 00 00 00 00: no mem_we_o; done_o=1 the cycle after the 4th byte.
- Header 01 04 00 00 (1025) with DEPTH_WORDS=1024: err_o=1, core_rst_o stays 1, later bytes cause no writes.
- Bytes on consecutive cycles across a word boundary: one strobe per word, no dropped byte, addresses 0x0, 0x4, 0x8.
- Timeout and reset:
  - Header 03 00 00 00, one data byte, then TIMEOUT_CYCLES idle: state returns to HDR and busy_o=0.
  - A fresh header 01 00 00 00 plus 4 bytes then writes addr 0x0.
  - rst_ni pulsed mid-word: all outputs return to reset values, and no stray mem_we_o after release.
